// File: rtl/reg_bank_mp.sv
// Multi-port register bank: byte-enable writes with a valid/ready handshake,
// registered reads with write-first forwarding, and a sequential clear engine.

module reg_bank_mp_rd_port #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_rd_valid,
    input  logic [ADDR_W-1:0]             i_rd_addr,
    input  logic [DEPTH-1:0][DATA_W-1:0]  i_mem_nxt,
    output logic [DATA_W-1:0]             o_rd_data,
    output logic                          o_rd_data_valid
);
    logic              w_in_range;
    logic [DATA_W-1:0] w_rd_val;

    assign w_in_range = (32'(i_rd_addr) < DEPTH);

    // Reading the post-edge view of the bank gives write-first forwarding for free.
    always_comb begin
        w_rd_val = '0;
        if (w_in_range) w_rd_val = i_mem_nxt[i_rd_addr];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_rd_data       <= '0;
            o_rd_data_valid <= 1'b0;
        end else begin
            o_rd_data_valid <= i_rd_valid;
            if (i_rd_valid) o_rd_data <= w_rd_val;
        end
    end
endmodule

module reg_bank_mp #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int NUM_RD = 2
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_wr_valid,
    output logic                       o_wr_ready,
    input  logic [ADDR_W-1:0]          i_wr_addr,
    input  logic [DATA_W-1:0]          i_wr_data,
    input  logic [DATA_W/8-1:0]        i_wr_be,
    input  logic [NUM_RD-1:0]          i_rd_valid,
    input  logic [NUM_RD*ADDR_W-1:0]   i_rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   o_rd_data,
    output logic [NUM_RD-1:0]          o_rd_data_valid,
    input  logic                       i_clr_start,
    output logic                       o_busy,
    output logic                       o_clr_done
);
    localparam int NB = DATA_W / 8;
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    logic [0:0]                  r_state;
    logic [ADDR_W-1:0]           r_cnt;
    logic                        r_clr_done;
    logic [DEPTH-1:0][DATA_W-1:0] r_mem;

    logic [DEPTH-1:0][DATA_W-1:0] w_mem_nxt;
    logic                        w_wr_in_range;
    logic                        w_wr_fire;
    logic                        w_clr_fire;
    logic                        w_clr_last;
    logic [DATA_W-1:0]           w_wr_old;
    logic [DATA_W-1:0]           w_wr_merged;

    assign o_wr_ready    = (r_state == ST_IDLE);
    assign o_busy        = (r_state == ST_CLEAR);
    assign o_clr_done    = r_clr_done;
    assign w_wr_in_range = (32'(i_wr_addr) < DEPTH);
    // Out-of-range writes still handshake; they just never reach the array.
    assign w_wr_fire     = i_wr_valid & o_wr_ready & w_wr_in_range;
    assign w_clr_fire    = (r_state == ST_CLEAR);
    assign w_clr_last    = (r_cnt == ADDR_W'(DEPTH - 1));

    always_comb begin
        w_wr_old = '0;
        if (w_wr_in_range) w_wr_old = r_mem[i_wr_addr];
        w_wr_merged = w_wr_old;
        for (int k = 0; k < NB; k++) begin
            if (i_wr_be[k]) w_wr_merged[8*k +: 8] = i_wr_data[8*k +: 8];
        end
    end

    // Writes only fire in IDLE and clears only in CLEAR, so they never collide.
    always_comb begin
        w_mem_nxt = r_mem;
        if (w_wr_fire)  w_mem_nxt[i_wr_addr] = w_wr_merged;
        if (w_clr_fire) w_mem_nxt[r_cnt]     = '0;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_mem <= '0;
        else          r_mem <= w_mem_nxt;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_clr_done <= 1'b0;
        end else begin
            r_clr_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_clr_start) begin
                        r_state <= ST_CLEAR;
                        r_cnt   <= '0;
                    end
                end
                default: begin
                    if (w_clr_last) begin
                        r_state    <= ST_IDLE;
                        r_cnt      <= '0;
                        r_clr_done <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        reg_bank_mp_rd_port #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH),
            .ADDR_W (ADDR_W)
        ) u_rd (
            .i_clk           (i_clk),
            .i_rst_n         (i_rst_n),
            .i_rd_valid      (i_rd_valid[g]),
            .i_rd_addr       (i_rd_addr[g*ADDR_W +: ADDR_W]),
            .i_mem_nxt       (w_mem_nxt),
            .o_rd_data       (o_rd_data[g*DATA_W +: DATA_W]),
            .o_rd_data_valid (o_rd_data_valid[g])
        );
    end
endmodule

// File: tb/tb_reg_bank_mp.sv
// Bench for reg_bank_mp: directed vector table, hand-written clear/reset
// sequences and a randomized phase checked against an array-based model.

module tb_reg_bank_mp;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        wv;
    logic [3:0]  wa;
    logic [15:0] wd;
    logic [1:0]  be;
    logic [1:0]  rv;
    logic [3:0]  ra0, ra1;
    logic        clr;

    logic        wr_ready, busy, clr_done;
    logic [31:0] rd;
    logic [1:0]  rdv;
    logic        wr_ready12, busy12, clr_done12;
    logic [31:0] rd12;
    logic [1:0]  rdv12;

    always #5 clk = ~clk;

    reg_bank_mp #(.DATA_W(16), .DEPTH(16), .ADDR_W(4), .NUM_RD(2)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_wr_valid(wv), .o_wr_ready(wr_ready),
        .i_wr_addr(wa), .i_wr_data(wd), .i_wr_be(be), .i_rd_valid(rv),
        .i_rd_addr({ra1, ra0}), .o_rd_data(rd), .o_rd_data_valid(rdv),
        .i_clr_start(clr), .o_busy(busy), .o_clr_done(clr_done));

    reg_bank_mp #(.DATA_W(16), .DEPTH(12), .ADDR_W(4), .NUM_RD(2)) dut12 (
        .i_clk(clk), .i_rst_n(rst_n), .i_wr_valid(wv), .o_wr_ready(wr_ready12),
        .i_wr_addr(wa), .i_wr_data(wd), .i_wr_be(be), .i_rd_valid(rv),
        .i_rd_addr({ra1, ra0}), .o_rd_data(rd12), .o_rd_data_valid(rdv12),
        .i_clr_start(clr), .o_busy(busy12), .o_clr_done(clr_done12));

    int n_cmp = 0;
    int n_fail = 0;

    // Reference model of the DEPTH=16 instance
    logic [15:0] m_mem [16];
    logic [15:0] m_rd  [2];
    logic [1:0]  m_rdv;
    bit          m_clearing;
    int          m_cnt;
    bit          m_done;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_mem[i] = '0;
        m_rd[0] = '0; m_rd[1] = '0; m_rdv = '0;
        m_clearing = 0; m_cnt = 0; m_done = 0;
    endtask

    task automatic model_edge();
        logic [15:0] nm [16];
        logic [3:0]  ra [2];
        nm = m_mem;
        ra[0] = ra0; ra[1] = ra1;
        if (!m_clearing && wv)
            for (int k = 0; k < 2; k++) if (be[k]) nm[wa][8*k +: 8] = wd[8*k +: 8];
        if (m_clearing) nm[m_cnt] = '0;
        for (int p = 0; p < 2; p++) begin
            m_rdv[p] = rv[p];
            if (rv[p]) m_rd[p] = nm[ra[p]];
        end
        m_done = 0;
        if (m_clearing) begin
            if (m_cnt == 15) begin m_clearing = 0; m_cnt = 0; m_done = 1; end
            else m_cnt++;
        end else if (clr) begin
            m_clearing = 1; m_cnt = 0;
        end
        m_mem = nm;
    endtask

    task automatic step();
        chk("wr_ready", 64'(wr_ready), 64'(!m_clearing));
        model_edge();
        @(posedge clk);
        #1;
        chk("rd0", 64'(rd[15:0]), 64'(m_rd[0]));
        chk("rd1", 64'(rd[31:16]), 64'(m_rd[1]));
        chk("rdv", 64'(rdv), 64'(m_rdv));
        chk("busy", 64'(busy), 64'(m_clearing));
        chk("clr_done", 64'(clr_done), 64'(m_done));
    endtask

    task automatic idle_in();
        wv = 0; wa = 0; wd = 0; be = 0; rv = 0; ra0 = 0; ra1 = 0; clr = 0;
    endtask

    typedef struct {
        logic        wv;
        logic [3:0]  wa;
        logic [15:0] wd;
        logic [1:0]  be;
        logic [1:0]  rv;
        logic [3:0]  ra0, ra1;
        logic [15:0] e0, e1;
        logic [1:0]  ev;
    } vec_t;

    vec_t tbl [10];

    initial begin
        #1000000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1);
    end

    initial begin
        int busy_cnt, done_cnt;
        logic [15:0] exp0, exp1;

        tbl[0] = '{1'b1, 4'd3, 16'hA5A5, 2'b11, 2'b00, 4'd0, 4'd0, 16'h0000, 16'h0000, 2'b00};
        tbl[1] = '{1'b0, 4'd0, 16'h0000, 2'b00, 2'b01, 4'd3, 4'd0, 16'hA5A5, 16'h0000, 2'b01};
        tbl[2] = '{1'b1, 4'd5, 16'h1234, 2'b11, 2'b00, 4'd0, 4'd0, 16'hA5A5, 16'h0000, 2'b00};
        tbl[3] = '{1'b1, 4'd5, 16'hABCD, 2'b01, 2'b00, 4'd0, 4'd0, 16'hA5A5, 16'h0000, 2'b00};
        tbl[4] = '{1'b0, 4'd0, 16'h0000, 2'b00, 2'b01, 4'd5, 4'd0, 16'h12CD, 16'h0000, 2'b01};
        tbl[5] = '{1'b1, 4'd5, 16'hFFFF, 2'b00, 2'b10, 4'd0, 4'd5, 16'h12CD, 16'h12CD, 2'b10};
        tbl[6] = '{1'b1, 4'd2, 16'h0042, 2'b11, 2'b00, 4'd0, 4'd0, 16'h12CD, 16'h12CD, 2'b00};
        tbl[7] = '{1'b1, 4'd7, 16'hBEEF, 2'b11, 2'b11, 4'd7, 4'd2, 16'hBEEF, 16'h0042, 2'b11};
        tbl[8] = '{1'b0, 4'd0, 16'h0000, 2'b00, 2'b00, 4'd0, 4'd0, 16'hBEEF, 16'h0042, 2'b00};
        tbl[9] = '{1'b0, 4'd0, 16'h0000, 2'b00, 2'b11, 4'd7, 4'd7, 16'hBEEF, 16'hBEEF, 2'b11};

        idle_in();
        model_reset();
        rst_n = 0;
        repeat (3) @(negedge clk);
        chk("rst_rd", 64'(rd), 64'd0);
        chk("rst_rdv", 64'(rdv), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(clr_done), 64'd0);
        chk("rst_ready", 64'(wr_ready), 64'd1);
        rst_n = 1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            wv = tbl[i].wv; wa = tbl[i].wa; wd = tbl[i].wd; be = tbl[i].be;
            rv = tbl[i].rv; ra0 = tbl[i].ra0; ra1 = tbl[i].ra1; clr = 0;
            step();
            chk($sformatf("vec%0d_rd0", i), 64'(rd[15:0]), 64'(tbl[i].e0));
            chk($sformatf("vec%0d_rd1", i), 64'(rd[31:16]), 64'(tbl[i].e1));
            chk($sformatf("vec%0d_rdv", i), 64'(rdv), 64'(tbl[i].ev));
        end

        // DEPTH=12 instance: out-of-range write dropped, out-of-range read is 0
        idle_in(); wv = 1; wa = 13; wd = 16'hDEAD; be = 2'b11; step();
        idle_in(); rv = 2'b01; ra0 = 13; step();
        chk("d12_oor_rd", 64'(rd12[15:0]), 64'd0);
        chk("d12_oor_rdv", 64'(rdv12[0]), 64'd1);
        idle_in(); wv = 1; wa = 11; wd = 16'h0B0B; be = 2'b11; step();
        idle_in(); rv = 2'b01; ra0 = 11; step();
        chk("d12_last_rd", 64'(rd12[15:0]), 64'h0B0B);

        // Clear sweep with a simultaneous write to the last entry
        for (int i = 0; i < 16; i++) begin
            idle_in(); wv = 1; wa = 4'(i); wd = 16'h1001 + 16'(i) * 16'h0111; be = 2'b11;
            step();
        end
        idle_in(); wv = 1; wa = 15; wd = 16'h7777; be = 2'b11; clr = 1;
        step();
        chk("clr_busy_start", 64'(busy), 64'd1);
        busy_cnt = busy ? 1 : 0;
        done_cnt = 0;
        wv = 1; wa = 4; wd = 16'h5555; be = 2'b11;
        for (int j = 0; j < 40; j++) begin
            rv = (j == 2) ? 2'b11 : 2'b00; ra0 = 0; ra1 = 15;
            clr = (j == 5);
            step();
            if (j == 2) begin
                chk("clr_rd_cleared", 64'(rd[15:0]), 64'd0);
                chk("clr_rd_pending", 64'(rd[31:16]), 64'h7777);
            end
            if (busy) busy_cnt++;
            if (clr_done) done_cnt++;
            if (!busy) break;
        end
        chk("clr_busy_cycles", 64'(busy_cnt), 64'd16);
        chk("clr_done_pulses", 64'(done_cnt), 64'd1);
        clr = 0; rv = 0;
        chk("held_wr_ready", 64'(wr_ready), 64'd1);
        step();
        wv = 0;
        for (int a = 0; a < 16; a += 2) begin
            rv = 2'b11; ra0 = 4'(a); ra1 = 4'(a + 1);
            step();
            exp0 = (a == 4) ? 16'h5555 : 16'h0000;
            exp1 = 16'h0000;
            chk($sformatf("post_clr_%0d", a), 64'(rd[15:0]), 64'(exp0));
            chk($sformatf("post_clr_%0d", a + 1), 64'(rd[31:16]), 64'(exp1));
        end

        // Reset in the middle of a clear
        idle_in(); wv = 1; wa = 9; wd = 16'h9999; be = 2'b11; step();
        idle_in(); clr = 1; step();
        idle_in(); rv = 2'b01; ra0 = 9;
        repeat (5) step();
        chk("pre_rst_rd", 64'(rd[15:0]), 64'h9999);
        #3;
        rst_n = 0;
        #1;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_rdv", 64'(rdv), 64'd0);
        chk("midrst_rd", 64'(rd), 64'd0);
        chk("midrst_done", 64'(clr_done), 64'd0);
        model_reset();
        idle_in();
        repeat (2) @(negedge clk);
        rst_n = 1;
        done_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (clr_done) done_cnt++;
        end
        chk("midrst_no_done", 64'(done_cnt), 64'd0);
        for (int a = 0; a < 16; a += 2) begin
            rv = 2'b11; ra0 = 4'(a); ra1 = 4'(a + 1);
            step();
            chk($sformatf("midrst_rd_%0d", a), 64'(rd), 64'd0);
        end

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            wv  = 1'($urandom_range(0, 1));
            wa  = 4'($urandom_range(0, 15));
            wd  = 16'($urandom);
            be  = 2'($urandom_range(0, 3));
            rv  = 2'($urandom_range(0, 3));
            ra0 = 4'($urandom_range(0, 15));
            ra1 = ($urandom_range(0, 3) == 0) ? wa : 4'($urandom_range(0, 15));
            clr = ($urandom_range(0, 24) == 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/reg_bank_mp.md
Name: reg_bank_mp

Overview:
- Parametrised multi-port register bank with its own controller. Successor to the fixed 16x16 single-read bank in the top-level datapath.
- Adds the following:
  - configurable width, depth and read-port count;
  - valid/ready write handshake with byte enables;
  - registered reads with write-first forwarding;
  - a sequential bank-clear engine.
- Sits between the control unit and the datapath, replacing the reg-file/control-unit pair.

Parameters:
- DATA_W, 16, data width in bits; multiple of 8.
- DEPTH, 16, number of entries; 2..2**ADDR_W.
- ADDR_W, 4, address width.
- NUM_RD, 2, number of independent read ports; 1..4.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset.
- wr_valid  in  1  write request.
- wr_ready  out  1  write can be accepted this cycle.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- wr_be  in  DATA_W/8  byte enables; bit k covers wr_data[8k+7:8k].
- rd_valid  in  NUM_RD  per-port read request.
- rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port i at [i*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*DATA_W  packed registered read data.
- rd_data_valid  out  NUM_RD  per-port read-data-valid.
- clr_start  in  1  request clear of all entries.
- busy  out  1  clear in progress.
- clr_done  out  1  one-cycle pulse when clear completes.

Behaviour:
- Reset: while rst=0, asynchronously:
  - all entries = 0, rd_data = 0, rd_data_valid = 0;
  - state = IDLE, clear counter = 0, busy = 0, clr_done = 0.
- wr_ready is combinational = (state==IDLE). It is 1 immediately after reset.
- Write:
  - Accepted on an edge where wr_valid & wr_ready.
  - Only bytes with wr_be=1 are updated; other bytes hold.
  - wr_be=0 is accepted with no change.
  - wr_addr>=DEPTH is accepted and dropped.
  - wr_valid with wr_ready=0 is not accepted. The requester holds wr_valid/addr/data/be until it sees ready.
- Read (each port independent, identical behaviour):
  - Latency is 1 cycle. On the edge where rd_valid[i]=1, rd_data port i loads the entry at its address, and rd_data_valid[i] is 1 for the following cycle.
  - If rd_valid[i]=0, rd_data port i holds its previous value and rd_data_valid[i]=0.
  - rd_addr>=DEPTH returns 0.
  - Write-first forwarding: a read of an address written (or cleared) on the same edge returns the post-write merged value.
  - Multiple ports reading the same address all get the same value.
  - Reads are allowed in every state, including CLEAR.
- Clear FSM: states IDLE, CLEAR.
  - IDLE -> CLEAR on an edge with clr_start=1. Counter is set to 0 and busy becomes 1.
  - In CLEAR, each edge writes entry[cnt]=0 and then increments cnt.
  - On the edge that clears entry DEPTH-1: state -> IDLE, counter -> 0, busy -> 0, and clr_done = 1 for exactly one cycle.
  - busy is high for exactly DEPTH cycles.
  - clr_start while busy is ignored; it is not queued.
- Simultaneous events:
  - clr_start and an accepted write on the same IDLE edge: the write commits, then the clear starts and zeros that entry in turn.
  - A read during CLEAR returns 0 for already-cleared entries and current contents for the rest.
- Reset mid-clear: asserting rst aborts the clear. All entries are zeroed by reset, and no clr_done pulse is produced.

Test Plan:
- Reset then full write/read:
  - Release rst.
  - Write 0xA5A5 to addr 3 with wr_be=11, then read port0 addr 3 -> rd_data port0 = 0xA5A5 with rd_data_valid[0]=1 one cycle after the request.
  - rd_data = 0 before any read.
- Byte enables:
  - addr 5 holds 0x1234.
  - Write 0xABCD with wr_be=01 -> read returns 0x12CD.
  - Write with wr_be=00 -> still 0x12CD.
- Forwarding and multi-port:
  - Same edge: write 0xBEEF to addr 7, port0 reads addr 7, port1 reads addr 2 (holds 0x0042).
  - Next cycle: port0 = 0xBEEF, port1 = 0x0042, rd_data_valid = 11.
- Clear sweep (DEPTH=16):
  - Fill all entries with nonzero values, then pulse clr_start.
  - Expected: wr_ready=0 and busy=1 for 16 cycles; clr_done pulses once; all reads then return 0.
  - A write held during the clear is accepted on the first cycle after busy drops.
  - clr_start pulsed mid-clear has no effect.
- Simultaneous and boundary cases:
  - clr_start plus a write to addr 15 on the same edge -> addr 15 reads 0 after clr_done.
  - Read addr 0 at clear cycle 2 -> 0; read addr 15 at the same cycle -> old value.
  - With DEPTH=12: write to addr 13 is dropped and a read of addr 13 returns 0.
- Reset mid-clear:
  - Assert rst at clear cycle 5 (async, between edges) -> busy=0 and rd_data_valid=0 immediately.
  - No clr_done pulse; all entries read 0 after release.
